mips_bus_arbiter: RTL and testbench
===================================

Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-MM memory port between the CPU's instruction-fetch master (port i) and data load/store master (port d).
- Sits between the CPU core masters and the external Avalon slave: the RAM, with its variable waitrequest latency.
- Grants one master per transaction and holds the grant until the slave completes.
- A watchdog aborts transactions the slave never completes.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width; byteenable width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, maximum granted cycles with waitrequest high before abort; 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_address  in  ADDR_WIDTH  fetch master address.
- i_read  in  1  fetch read request.
- i_waitrequest  out  1  stall to fetch master.
- i_readdata  out  DATA_WIDTH  read data to fetch master.
- d_address  in  ADDR_WIDTH  data master address.
- d_read  in  1  data read request.
- d_write  in  1  data write request.
- d_writedata  in  DATA_WIDTH  data write data.
- d_byteenable  in  DATA_WIDTH/8  data byte lanes.
- d_waitrequest  out  1  stall to data master.
- d_readdata  out  DATA_WIDTH  read data to data master.
- address  out  ADDR_WIDTH  slave address.
- read  out  1  slave read.
- write  out  1  slave write.
- writedata  out  DATA_WIDTH  slave write data.
- byteenable  out  DATA_WIDTH/8  slave byte lanes.
- waitrequest  in  1  slave stall.
- readdata  in  DATA_WIDTH  slave read data.
- bus_error  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D.
- Reset (reset=0) asynchronously forces:
  - state=IDLE, watchdog counter=0, bus_error=0;
  - read=0, write=0, address=0, writedata=0, byteenable=0;
  - i_waitrequest=1, d_waitrequest=1.
- IDLE:
  - Slave read/write are 0; both upstream waitrequests are 1.
  - On a clock edge, if d_read|d_write, go to GNT_D (data has priority: a stalled load/store blocks the pipeline). Otherwise, if i_read, go to GNT_I.
  - Arbitration latency is exactly one cycle from request to slave strobe.
- GNT_x routing (combinational pass-through):
  - The granted master's address/read/write/writedata/byteenable drive the slave.
  - Port i always drives write=0 and byteenable=all ones.
  - Granted waitrequest = slave waitrequest; the non-granted master's waitrequest = 1.
- readdata from the slave is broadcast to both i_readdata and d_readdata.
- d_read and d_write both high: write wins; read is forced to 0 downstream.
- Completion: on the clock edge where the granted strobe is high and waitrequest=0, the transaction is complete.
  - If the other master is requesting, the next state is the other master's grant (back-to-back, no IDLE bubble). Otherwise the next state is IDLE.
  - A second request from the same master re-arbitrates via IDLE, so the other master cannot starve.
- Granted master drops its strobe before completion: treated as a cancel; return to IDLE next edge.
- Watchdog:
  - Counter clears on every grant and increments each GNT cycle with waitrequest=1.
  - When it reaches TIMEOUT_CYCLES: bus_error=1 for one cycle, the granted master sees waitrequest=0 for that cycle (readdata undefined), then go to IDLE.
- Counter width: clog2(TIMEOUT_CYCLES+1); no wrap.

Optional Feature:
- Macro: MIPS_BUS_ARB_RR_EN.
- Defined: the IDLE priority becomes round-robin. A last_grant flop (reset value = I) gives priority to the master not served last when both request in IDLE.
- Undefined: fixed data-over-fetch priority as above; last_grant is not implemented.

Test Plan:
- Reset mid-transaction: assert reset low while in GNT_D with write=1 → write=0, d_waitrequest=1 immediately (same cycle, asynchronous); state IDLE after release.
- Single fetch: i_read=1, i_address=0xBFC00000, slave waitrequest low after 2 cycles with readdata=0x24020005 → read high from cycle 1, i_readdata=0x24020005 on the completion edge, d_waitrequest=1 throughout.
- Simultaneous requests: i_read and d_write (0xBFC00400, 0xDEADBEEF, byteenable 0xF) together → write served first, fetch granted the cycle after write completion with no IDLE gap. With MIPS_BUS_ARB_RR_EN and last_grant=D, fetch is served first.
- Write wins: d_read=1 and d_write=1 → slave sees write=1, read=0.
- Watchdog: TIMEOUT_CYCLES=4, slave waitrequest stuck high on a fetch → bus_error pulses exactly once on the 4th granted cycle; i_waitrequest=0 that cycle; IDLE next.
- Cancel: d_read dropped after one waited cycle → read=0 next cycle, state IDLE, no bus_error.

Source files
------------

// File: rtl/mips_bus_arbiter_if.sv
// Bus bundle for mips_bus_arbiter: fetch master (i_*), data master (d_*) and
// the shared Avalon-MM slave port, plus the watchdog abort pulse.
interface mips_bus_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Fetch master side
    logic [ADDR_WIDTH-1:0]   i_address;
    logic                    i_read;
    logic                    i_waitrequest;
    logic [DATA_WIDTH-1:0]   i_readdata;

    // Data master side
    logic [ADDR_WIDTH-1:0]   d_address;
    logic                    d_read;
    logic                    d_write;
    logic [DATA_WIDTH-1:0]   d_writedata;
    logic [DATA_WIDTH/8-1:0] d_byteenable;
    logic                    d_waitrequest;
    logic [DATA_WIDTH-1:0]   d_readdata;

    // Shared slave side
    logic [ADDR_WIDTH-1:0]   address;
    logic                    read;
    logic                    write;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic                    waitrequest;
    logic [DATA_WIDTH-1:0]   readdata;

    logic                    bus_error;

    // Arbiter view: slave to both CPU masters, master towards the memory.
    modport slave (
        input  i_address, i_read,
        output i_waitrequest, i_readdata,
        input  d_address, d_read, d_write, d_writedata, d_byteenable,
        output d_waitrequest, d_readdata,
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata,
        output bus_error
    );

    // Environment view: CPU masters and the memory model.
    modport master (
        output i_address, i_read,
        input  i_waitrequest, i_readdata,
        output d_address, d_read, d_write, d_writedata, d_byteenable,
        input  d_waitrequest, d_readdata,
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata,
        input  bus_error
    );
endinterface

// File: rtl/mips_bus_arbiter.sv
// Two-master Avalon-MM arbiter (fetch vs load/store) with a waitrequest watchdog.
// Define MIPS_BUS_ARB_RR_EN for round-robin IDLE priority; default is data-over-fetch.
module mips_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                reset,
    mips_bus_arbiter_if.slave   bus
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        GNT_I,
        GNT_D
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] wd_cnt;
    logic [CNT_W-1:0] wd_cnt_nx;
    logic             i_req;
    logic             d_req;
    logic             pick_d;
    logic             wd_fire;

    assign i_req = bus.i_read;
    assign d_req = bus.d_read | bus.d_write;

`ifdef MIPS_BUS_ARB_RR_EN
    typedef enum logic {
        LAST_I,
        LAST_D
    } last_t;

    last_t last_grant;

    // Ties go to whichever master was not served by the previous grant.
    assign pick_d = d_req & (~i_req | (last_grant == LAST_I));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= LAST_I;
        end else if (state_nx != state) begin
            if (state_nx == GNT_D) begin
                last_grant <= LAST_D;
            end else if (state_nx == GNT_I) begin
                last_grant <= LAST_I;
            end
        end
    end
`else
    assign pick_d = d_req;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            wd_cnt <= wd_cnt_nx;
        end
    end

    // Routing and next-state; wd_fire completes the granted master early.
    always_comb begin
        state_nx          = state;
        wd_fire           = 1'b0;
        bus.address       = '0;
        bus.read          = 1'b0;
        bus.write         = 1'b0;
        bus.writedata     = '0;
        bus.byteenable    = '0;
        bus.i_waitrequest = 1'b1;
        bus.d_waitrequest = 1'b1;

        case (state)
            IDLE: begin
                if (pick_d) begin
                    state_nx = GNT_D;
                end else if (i_req) begin
                    state_nx = GNT_I;
                end
            end

            GNT_I: begin
                bus.address       = bus.i_address;
                bus.read          = bus.i_read;
                bus.byteenable    = '1;
                wd_fire           = WD_EN && i_req && bus.waitrequest && (wd_cnt == CNT_LAST);
                bus.i_waitrequest = bus.waitrequest & ~wd_fire;
                if (!i_req || wd_fire) begin
                    state_nx = IDLE;
                end else if (!bus.waitrequest) begin
                    state_nx = d_req ? GNT_D : IDLE;
                end
            end

            GNT_D: begin
                bus.address       = bus.d_address;
                bus.read          = bus.d_read & ~bus.d_write;
                bus.write         = bus.d_write;
                bus.writedata     = bus.d_writedata;
                bus.byteenable    = bus.d_byteenable;
                wd_fire           = WD_EN && d_req && bus.waitrequest && (wd_cnt == CNT_LAST);
                bus.d_waitrequest = bus.waitrequest & ~wd_fire;
                if (!d_req || wd_fire) begin
                    state_nx = IDLE;
                end else if (!bus.waitrequest) begin
                    state_nx = i_req ? GNT_I : IDLE;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Any change of state is a fresh grant (or a release), so the count restarts.
    always_comb begin
        wd_cnt_nx = wd_cnt;
        if (state == IDLE || state_nx != state) begin
            wd_cnt_nx = '0;
        end else if (bus.waitrequest && wd_cnt != CNT_MAX) begin
            wd_cnt_nx = wd_cnt + 1'b1;
        end
    end

    assign bus.i_readdata = bus.readdata;
    assign bus.d_readdata = bus.readdata;
    assign bus.bus_error  = wd_fire;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Self-checking bench for mips_bus_arbiter: directed scenarios then random
// traffic, all checked against a transaction-level ownership model.
module tb_mips_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mips_bus_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mips_bus_arbiter #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the bus (0 none, 1 fetch, 2 data),
    // how many stalled cycles the owner has seen, and who was served last.
    int owner  = 0;
    int waited = 0;
    int last   = 1;
    bit m_strobe;
    bit m_fire;
    logic [DW/8-1:0] all_be = '1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after the negedge that applied this cycle's inputs.
    task automatic settle(input string tag);
        logic ireq, dreq, e_read, e_write, e_iw, e_dw;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [DW/8-1:0] e_be;
        #1;
        ireq     = bus.i_read;
        dreq     = bus.d_read | bus.d_write;
        m_strobe = (owner == 1) ? ireq : (owner == 2) ? dreq : 1'b0;
        m_fire   = m_strobe && bus.waitrequest && (TO > 0) && (waited + 1 >= TO);
        e_read   = (owner == 1) ? bus.i_read : (owner == 2) ? (bus.d_read && !bus.d_write) : 1'b0;
        e_write  = (owner == 2) && bus.d_write;
        e_addr   = (owner == 1) ? bus.i_address : (owner == 2) ? bus.d_address : '0;
        e_wd     = (owner == 2) ? bus.d_writedata : '0;
        e_be     = (owner == 1) ? all_be : (owner == 2) ? bus.d_byteenable : '0;
        e_iw     = (owner == 1) ? (bus.waitrequest && !m_fire) : 1'b1;
        e_dw     = (owner == 2) ? (bus.waitrequest && !m_fire) : 1'b1;
        check({tag, ".read"},       bus.read,          e_read);
        check({tag, ".write"},      bus.write,         e_write);
        check({tag, ".address"},    bus.address,       e_addr);
        check({tag, ".writedata"},  bus.writedata,     e_wd);
        check({tag, ".byteenable"}, bus.byteenable,    e_be);
        check({tag, ".i_wait"},     bus.i_waitrequest, e_iw);
        check({tag, ".d_wait"},     bus.d_waitrequest, e_dw);
        check({tag, ".bus_error"},  bus.bus_error,     m_fire);
        check({tag, ".i_rdata"},    bus.i_readdata,    bus.readdata);
        check({tag, ".d_rdata"},    bus.d_readdata,    bus.readdata);
    endtask

    task automatic advance();
        logic ireq, dreq;
        int other;
        ireq = bus.i_read;
        dreq = bus.d_read | bus.d_write;
        if (owner == 0) begin
`ifdef MIPS_BUS_ARB_RR_EN
            if (ireq && dreq) owner = (last == 2) ? 1 : 2;
            else if (dreq) owner = 2;
            else if (ireq) owner = 1;
`else
            if (dreq) owner = 2;
            else if (ireq) owner = 1;
`endif
            if (owner != 0) begin
                waited = 0;
                last   = owner;
            end
        end else if (!m_strobe || m_fire) begin
            owner = 0;
        end else if (!bus.waitrequest) begin
            other = 3 - owner;
            if ((other == 1 && ireq) || (other == 2 && dreq)) begin
                owner  = other;
                waited = 0;
                last   = owner;
            end else begin
                owner = 0;
            end
        end else begin
            waited++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        advance();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.i_read       = 1'b0;
        bus.i_address    = '0;
        bus.d_read       = 1'b0;
        bus.d_write      = 1'b0;
        bus.d_address    = '0;
        bus.d_writedata  = '0;
        bus.d_byteenable = '0;
        bus.waitrequest  = 1'b1;
        bus.readdata     = '0;
    endtask

    task automatic idle(input string tag, input int n);
        clear_inputs();
        for (int k = 0; k < n; k++) begin
            settle(tag);
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        bus.d_write = 1'b1;
        @(negedge clk);
        @(negedge clk);
        settle("reset");
        check("reset.write_held_low", bus.write, 1'b0);
        reset = 1'b1;
        idle("post_reset", 1);

        // Single fetch, two stalled cycles then data.
        bus.i_read = 1'b1;
        bus.i_address = 32'hBFC00000;
        settle("fetch.arb");
        tick();
        for (int k = 1; k <= 3; k++) begin
            bus.waitrequest = (k < 3);
            bus.readdata    = (k == 3) ? 32'h24020005 : 32'h0;
            settle("fetch.gnt");
            check("fetch.read", bus.read, 1'b1);
            check("fetch.d_wait", bus.d_waitrequest, 1'b1);
            if (k == 3) begin
                check("fetch.rdata", bus.i_readdata, 32'h24020005);
                check("fetch.i_wait_done", bus.i_waitrequest, 1'b0);
            end
            tick();
        end
        idle("fetch.after", 2);

        // Simultaneous fetch and write: write first, fetch back-to-back.
        bus.i_read = 1'b1;
        bus.i_address = 32'hBFC00004;
        bus.d_write = 1'b1;
        bus.d_address = 32'hBFC00400;
        bus.d_writedata = 32'hDEADBEEF;
        bus.d_byteenable = 4'hF;
        settle("simul.arb");
        tick();
        bus.waitrequest = 1'b0;
        settle("simul.wr");
        check("simul.write", bus.write, 1'b1);
        check("simul.wr_addr", bus.address, 32'hBFC00400);
        check("simul.wdata", bus.writedata, 32'hDEADBEEF);
        tick();
        bus.d_write = 1'b0;
        settle("simul.rd");
        check("simul.fetch_no_gap", bus.read, 1'b1);
        check("simul.rd_addr", bus.address, 32'hBFC00004);
        tick();
        idle("simul.after", 2);

        // Write wins over read.
        bus.d_read = 1'b1;
        bus.d_write = 1'b1;
        bus.d_address = 32'h00001000;
        bus.d_writedata = 32'h12345678;
        bus.d_byteenable = 4'h3;
        bus.waitrequest = 1'b0;
        settle("rw.arb");
        tick();
        settle("rw.gnt");
        check("rw.write", bus.write, 1'b1);
        check("rw.read_forced_low", bus.read, 1'b0);
        tick();
        idle("rw.after", 2);

        // Watchdog: slave stuck on a fetch.
        bus.i_read = 1'b1;
        bus.i_address = 32'h00002000;
        settle("wd.arb");
        tick();
        for (int k = 1; k <= TO; k++) begin
            settle("wd.gnt");
            check("wd.bus_error", bus.bus_error, (k == TO));
            check("wd.i_wait", bus.i_waitrequest, (k != TO));
            tick();
        end
        settle("wd.idle");
        check("wd.idle_read", bus.read, 1'b0);
        check("wd.single_pulse", bus.bus_error, 1'b0);
        tick();
        idle("wd.after", 2);

        // Cancel: data read dropped after one stalled cycle.
        bus.d_read = 1'b1;
        bus.d_address = 32'h00003000;
        settle("cancel.arb");
        tick();
        settle("cancel.gnt");
        check("cancel.read", bus.read, 1'b1);
        tick();
        bus.d_read = 1'b0;
        settle("cancel.drop");
        check("cancel.no_error", bus.bus_error, 1'b0);
        tick();
        bus.d_read = 1'b1;
        settle("cancel.idle");
        check("cancel.idle_read", bus.read, 1'b0);
        tick();
        idle("cancel.after", 3);

        // Reset in the middle of a stalled write.
        bus.d_write = 1'b1;
        bus.d_address = 32'h00004000;
        bus.d_writedata = 32'hCAFEF00D;
        bus.d_byteenable = 4'hC;
        settle("rst.arb");
        tick();
        settle("rst.gnt");
        check("rst.write_before", bus.write, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("rst.async_write", bus.write, 1'b0);
        check("rst.async_d_wait", bus.d_waitrequest, 1'b1);
        owner  = 0;
        waited = 0;
        last   = 1;
        @(negedge clk);
        reset = 1'b1;
        settle("rst.release");
        check("rst.idle_write", bus.write, 1'b0);
        tick();
        idle("rst.after", 3);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 9) < 3) bus.i_read = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 9) < 3) begin
                bus.d_read  = $urandom_range(0, 2) == 0;
                bus.d_write = $urandom_range(0, 2) == 0;
            end
            bus.i_address    = $urandom;
            bus.d_address    = $urandom;
            bus.d_writedata  = $urandom;
            bus.d_byteenable = 4'($urandom_range(0, 15));
            bus.waitrequest  = $urandom_range(0, 9) < 6;
            bus.readdata     = $urandom;
            settle("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
